// File: rtl/cic_decim.sv
// -----------------------------------------------------------------------------
// cic_decim -- 3rd-order CIC decimator (rate 8, differential delay 1) for a
// 1-bit sigma-delta bitstream, with a valid/ready output handshake.
//
// Ports
//   clock    in   1   system clock, all state updates on rising edge
//   reset    in   1   asynchronous active-high reset
//   bit_in   in   1   modulator bit: 1 -> +1, 0 -> -1
//   bit_en   in   1   bit_in is accepted on an edge only while bit_en = 1
//   v_out    out  15  signed decimated sample, full scale +/-16384
//   v_valid  out  1   v_out holds a sample not yet consumed
//   v_ready  in   1   consumer takes v_out on an edge with v_valid & v_ready
//   overrun  out  1   sticky: an unconsumed sample was overwritten
//
// Configuration
//   CIC_DECIM_SAT_EN  when defined, a scaled result of +16384 clamps to
//                     +16383; otherwise the result is truncated to 15 bits
//                     and +16384 wraps to -16384.
//
// All datapath registers are 11-bit two's complement and wrap freely; the CIC
// structure guarantees the comb output is correct modulo 2^11, and the true
// result (-512..+512) fits in that width.
// -----------------------------------------------------------------------------
module cic_decim (
    input  logic        clock,
    input  logic        reset,
    input  logic        bit_in,
    input  logic        bit_en,
    output logic [14:0] v_out,
    output logic        v_valid,
    input  logic        v_ready,
    output logic        overrun
);
    localparam int W      = 11;
    localparam int STAGES = 3;

    // +1 for a one, -1 (all ones) for a zero.
    logic signed [W-1:0] x;
    assign x = {{(W-1){~bit_in}}, 1'b1};

    // -------------------------------------------------------------------------
    // Integrators. Every stage adds the previous stage's registered value, so
    // the cascade is fully pipelined (i2 and i3 lag by one and two bits); the
    // lag is constant and well inside one decimation period.
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_integ
            logic signed [W-1:0] acc_reg;
            logic signed [W-1:0] add_in;

            if (gi == 0) begin : g_first
                assign add_in = x;
            end else begin : g_rest
                assign add_in = g_integ[gi-1].acc_reg;
            end

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    acc_reg <= '0;
                end else if (bit_en) begin
                    acc_reg <= acc_reg + add_in;
                end
            end
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Phase counter and decimation tick. The tick is registered, so it is high
    // in the cycle after the 8th bit of a group was accepted.
    // -------------------------------------------------------------------------
    logic [2:0] phase_reg;
    logic       tick_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            phase_reg <= 3'd0;
            tick_reg  <= 1'b0;
        end else begin
            tick_reg <= bit_en && (phase_reg == 3'd7);
            if (bit_en) begin
                phase_reg <= phase_reg + 3'd1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Combs. The subtractions are combinational from the (stable) i3 value in
    // the tick cycle; each delay register captures its stage input only on a
    // tick, which is what makes them run at the decimated rate.
    // -------------------------------------------------------------------------
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_comb
            logic signed [W-1:0] dly_reg;
            logic signed [W-1:0] comb_in;
            logic signed [W-1:0] diff;

            if (gi == 0) begin : g_first
                assign comb_in = g_integ[STAGES-1].acc_reg;
            end else begin : g_rest
                assign comb_in = g_comb[gi-1].diff;
            end

            assign diff = comb_in - dly_reg;

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    dly_reg <= '0;
                end else if (tick_reg) begin
                    dly_reg <= comb_in;
                end
            end
        end
    endgenerate

    logic signed [W-1:0] c3;
    assign c3 = g_comb[STAGES-1].diff;

    // -------------------------------------------------------------------------
    // Output scaling: c3 * 32. Only +512 (all-ones density) overflows 15 bits.
    // -------------------------------------------------------------------------
    logic [14:0] sample_next;

`ifdef CIC_DECIM_SAT_EN
    logic signed [15:0] scaled;
    assign scaled = {c3, 5'b00000};

    always_comb begin
        sample_next = scaled[14:0];
        if (scaled > 16'sd16383) begin
            sample_next = 15'h3FFF;
        end else if (scaled < -16'sd16384) begin
            sample_next = 15'h4000;
        end
    end
`else
    // Plain truncation: +16384 wraps to -16384.
    assign sample_next = 15'({c3, 5'b00000});
`endif

    // -------------------------------------------------------------------------
    // Output register and handshake. A load always wins over a consume, so a
    // sample taken on the same edge as a new load leaves v_valid set; only a
    // load over a sample nobody took marks an overrun.
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            v_out   <= 15'd0;
            v_valid <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (tick_reg) begin
                v_out   <= sample_next;
                v_valid <= 1'b1;
                if (v_valid && !v_ready) begin
                    overrun <= 1'b1;
                end
            end else if (v_valid && v_ready) begin
                v_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cic_decim.sv
// -----------------------------------------------------------------------------
// tb_cic_decim -- directed, table-driven bench for cic_decim.
// Steady-state vectors are applied from a table; latency, handshake,
// backpressure/overrun and mid-group reset are hand-written sequences.
// Hand-computed reference for the pattern 1,1,1,0 from reset: the first three
// samples are c3 = 44, 228, 256, i.e. v_out = 1408, 7296, 8192.
// -----------------------------------------------------------------------------
module tb_cic_decim;
    logic        clock = 1'b0;
    logic        reset;
    logic        bit_in;
    logic        bit_en;
    logic [14:0] v_out;
    logic        v_valid;
    logic        v_ready;
    logic        overrun;

    cic_decim dut (
        .clock   (clock),
        .reset   (reset),
        .bit_in  (bit_in),
        .bit_en  (bit_en),
        .v_out   (v_out),
        .v_valid (v_valid),
        .v_ready (v_ready),
        .overrun (overrun)
    );

    always #5 clock = ~clock;

`ifdef CIC_DECIM_SAT_EN
    localparam int ALLONES = 16383;
`else
    localparam int ALLONES = -16384;
`endif

    int checks   = 0;
    int failures = 0;

    // Sample monitor: records every cycle v_valid is high, 2 time units after
    // the edge (inputs change 1 unit after the edge).
    int cyc = 0;
    int samp_q[$];
    int cyc_q[$];

    always @(posedge clock) begin
        #2;
        cyc++;
        if (v_valid === 1'b1) begin
            samp_q.push_back(int'($signed(v_out)));
            cyc_q.push_back(cyc);
        end
    end

    task automatic check(input string name, input logic signed [31:0] actual,
                         input logic signed [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end else begin
            $display("ok   %s: got %0d", name, actual);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One accepted bit followed by gap-1 idle cycles.
    task automatic feed(input logic b, input int gap);
        bit_in = b;
        bit_en = 1'b1;
        step();
        bit_en = 1'b0;
        repeat (gap - 1) step();
    endtask

    task automatic do_reset();
        bit_en  = 1'b0;
        bit_in  = 1'b0;
        v_ready = 1'b1;
        reset   = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    typedef struct {
        string      name;
        logic [3:0] pat;      // bits applied LSB first, repeating
        int         plen;
        int         gap;      // bit_en high one cycle in 'gap'
        int         exp_val;  // steady-state v_out
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{"alt_1_0",     4'b0001, 2, 1, 0};
        vecs[1] = '{"d34_1110",    4'b0111, 4, 1, 8192};
        vecs[2] = '{"d14_0001",    4'b1000, 4, 1, -8192};
        vecs[3] = '{"all_ones",    4'b1111, 4, 1, ALLONES};
        vecs[4] = '{"d34_gap3",    4'b0111, 4, 3, 8192};
        vecs[5] = '{"d14_gap3",    4'b1000, 4, 3, -8192};

        bit_en  = 1'b0;
        bit_in  = 1'b0;
        v_ready = 1'b1;
        reset   = 1'b1;
        #1;
        check("reset_v_out",   int'($signed(v_out)), 0);
        check("reset_v_valid", int'(v_valid), 0);
        check("reset_overrun", int'(overrun), 0);
        step();
        reset = 1'b0;
        step();

        // ---------------- table-driven steady-state vectors ----------------
        for (int v = 0; v < 6; v++) begin
            do_reset();
            samp_q.delete();
            cyc_q.delete();
            for (int i = 0; i < 48; i++) begin
                feed(vecs[v].pat[i % vecs[v].plen], vecs[v].gap);
            end
            step();
            step();
            check({vecs[v].name, "_count"}, samp_q.size(), 6);
            if (samp_q.size() >= 6) begin
                for (int k = 3; k < 6; k++) begin
                    check($sformatf("%s_s%0d", vecs[v].name, k + 1), samp_q[k], vecs[v].exp_val);
                end
                for (int k = 4; k < 6; k++) begin
                    check($sformatf("%s_period%0d", vecs[v].name, k + 1),
                          cyc_q[k] - cyc_q[k-1], 8 * vecs[v].gap);
                end
            end
        end

        // ---------------- latency: load one edge after the 8th bit ----------
        do_reset();
        for (int i = 0; i < 8; i++) feed((i % 4) != 3, 1);
        check("lat_valid_at_N", int'(v_valid), 0);
        step();
        check("lat_valid_at_N1", int'(v_valid), 1);
        check("lat_first_sample", int'($signed(v_out)), 1408);
        step();
        check("lat_consumed", int'(v_valid), 0);

        // ---------------- simultaneous consume and load ---------------------
        do_reset();
        v_ready = 1'b0;
        for (int i = 0; i < 8; i++) feed((i % 4) != 3, 1);
        for (int i = 8; i < 15; i++) feed((i % 4) != 3, 1);
        check("hold_valid", int'(v_valid), 1);
        check("hold_v_out", int'($signed(v_out)), 1408);
        feed(1'b0, 1);          // 16th bit accepted on this edge
        v_ready = 1'b1;         // consume on the same edge the new sample loads
        step();
        check("simul_valid", int'(v_valid), 1);
        check("simul_v_out", int'($signed(v_out)), 7296);
        check("simul_overrun", int'(overrun), 0);
        step();
        check("simul_then_empty", int'(v_valid), 0);

        // ---------------- backpressure across two ticks -> overrun ----------
        do_reset();
        v_ready = 1'b0;
        for (int i = 0; i < 16; i++) feed((i % 4) != 3, 1);
        step();
        check("ovr_v_out", int'($signed(v_out)), 7296);
        check("ovr_flag", int'(overrun), 1);
        v_ready = 1'b1;
        step();
        check("ovr_consumed", int'(v_valid), 0);
        check("ovr_sticky_1", int'(overrun), 1);
        for (int i = 16; i < 28; i++) feed((i % 4) != 3, 1);
        check("ovr_sticky_2", int'(overrun), 1);

        // ---------------- asynchronous mid-group reset ----------------------
        do_reset();
        v_ready = 1'b0;
        for (int i = 0; i < 21; i++) feed((i % 4) != 3, 1);   // 5 bits into group 3
        reset = 1'b1;
        #2;                                                    // no clock edge yet
        check("mid_rst_v_out",   int'($signed(v_out)), 0);
        check("mid_rst_v_valid", int'(v_valid), 0);
        check("mid_rst_overrun", int'(overrun), 0);
        reset   = 1'b0;
        v_ready = 1'b1;
        for (int i = 0; i < 7; i++) feed((i % 4) != 3, 1);
        step();
        step();
        check("mid_rst_no_early", int'(v_valid), 0);
        feed(1'b0, 1);
        step();
        check("mid_rst_fresh_valid", int'(v_valid), 1);
        check("mid_rst_fresh_v_out", int'($signed(v_out)), 1408);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
